alsu_result_checker: RTL and testbench

Synthesizable checker on the consuming side of the ALSU interface's output groups. Each qualified cycle it compares the DUT outputs (out, leds) against the golden-model outputs (out_ref, leds_ref). It keeps saturating pass/fail counters, captures the first mismatch with its context, and reports a run verdict. It sits beside the DUT and golden model in the ALSU verification environment and also serves as the on-FPGA self-check.

---
 rtl/alsu_result_checker.sv | 115 +++++++++++
 tb/tb_alsu_result_checker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_result_checker.sv
// Compares ALSU DUT outputs against golden-model outputs on qualified cycles,
// keeping saturating pass/fail counters, first-mismatch context and a run verdict.
module alsu_result_checker #(
   parameter int OUT_W       = 6,
   parameter int LED_W       = 16,
   parameter int CNT_W       = 16,
   parameter int NUM_SAMPLES = 0,
   parameter int STOP_ON_ERR = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    sample_en,
   input  logic [2:0]              opcode,
   input  logic signed [OUT_W-1:0] out,
   input  logic signed [OUT_W-1:0] out_ref,
   input  logic [LED_W-1:0]        leds,
   input  logic [LED_W-1:0]        leds_ref,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    mismatch,
   output logic [CNT_W-1:0]        sample_cnt,
   output logic [CNT_W-1:0]        err_cnt,
   output logic                    first_err_vld,
   output logic [CNT_W-1:0]        first_err_idx,
   output logic [2:0]              first_err_op,
   output logic signed [OUT_W-1:0] first_err_out,
   output logic signed [OUT_W-1:0] first_err_ref
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

   logic [1:0] state;
   logic       fail;
   logic       last;
   logic       end_run;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // case matching is exact, so an unknown compare result falls to the failing branch
   always_comb begin
      fail = 1'b1;
      case ((out == out_ref) && (leds == leds_ref))
         1'b1:    fail = 1'b0;
         default: fail = 1'b1;
      endcase
   end

   assign last    = (NUM_SAMPLES != 0) && (sample_cnt == LAST_IDX);
   assign end_run = stop || last || ((STOP_ON_ERR != 0) && fail);

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign pass = done && (err_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         mismatch      <= 1'b0;
         sample_cnt    <= '0;
         err_cnt       <= '0;
         first_err_vld <= 1'b0;
         first_err_idx <= '0;
         first_err_op  <= '0;
         first_err_out <= '0;
         first_err_ref <= '0;
      end else begin
         case (state)
            RUN: begin
               if (sample_en) begin
                  mismatch   <= fail;
                  sample_cnt <= sat_inc(sample_cnt);
                  if (fail) begin
                     err_cnt <= sat_inc(err_cnt);
                     if (!first_err_vld) begin
                        first_err_vld <= 1'b1;
                        first_err_idx <= sample_cnt;
                        first_err_op  <= opcode;
                        first_err_out <= out;
                        first_err_ref <= out_ref;
                     end
                  end
                  if (end_run) state <= DONE;
               end else begin
                  mismatch <= 1'b0;
                  if (stop) state <= DONE;
               end
            end
            default: begin
               mismatch <= 1'b0;
               // start wins over a simultaneous stop; the start cycle is never sampled
               if (start) begin
                  state         <= RUN;
                  sample_cnt    <= '0;
                  err_cnt       <= '0;
                  first_err_vld <= 1'b0;
                  first_err_idx <= '0;
                  first_err_op  <= '0;
                  first_err_out <= '0;
                  first_err_ref <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alsu_result_checker.sv
// Directed bench for alsu_result_checker: a vector table for the mixed pass/fail run
// plus hand-written sequences for run termination, saturation and reset.
module tb_alsu_result_checker;

   logic clk;
   logic rst, start, stop, sample_en;
   logic [2:0] opcode;
   logic signed [5:0] out_v, out_ref;
   logic [15:0] leds, leds_ref;

   int n_pass;
   int n_total;

   // default instance
   logic d_busy, d_done, d_pass, d_mis, d_fvld;
   logic [15:0] d_cnt, d_err, d_fidx;
   logic [2:0] d_fop;
   logic signed [5:0] d_fout, d_fref;
   // NUM_SAMPLES=4 instance
   logic n_busy, n_done, n_passo, n_mis, n_fvld;
   logic [15:0] n_cnt, n_err, n_fidx;
   logic [2:0] n_fop;
   logic signed [5:0] n_fout, n_fref;
   // STOP_ON_ERR=1 instance
   logic s_busy, s_done, s_pass, s_mis, s_fvld;
   logic [15:0] s_cnt, s_err, s_fidx;
   logic [2:0] s_fop;
   logic signed [5:0] s_fout, s_fref;
   // CNT_W=4 instance
   logic c_busy, c_done, c_pass, c_mis, c_fvld;
   logic [3:0] c_cnt, c_err, c_fidx;
   logic [2:0] c_fop;
   logic signed [5:0] c_fout, c_fref;

   alsu_result_checker u_dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
      .opcode(opcode), .out(out_v), .out_ref(out_ref), .leds(leds), .leds_ref(leds_ref),
      .busy(d_busy), .done(d_done), .pass(d_pass), .mismatch(d_mis),
      .sample_cnt(d_cnt), .err_cnt(d_err), .first_err_vld(d_fvld), .first_err_idx(d_fidx),
      .first_err_op(d_fop), .first_err_out(d_fout), .first_err_ref(d_fref));

   alsu_result_checker #(.NUM_SAMPLES(4)) u_ns (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
      .opcode(opcode), .out(out_v), .out_ref(out_ref), .leds(leds), .leds_ref(leds_ref),
      .busy(n_busy), .done(n_done), .pass(n_passo), .mismatch(n_mis),
      .sample_cnt(n_cnt), .err_cnt(n_err), .first_err_vld(n_fvld), .first_err_idx(n_fidx),
      .first_err_op(n_fop), .first_err_out(n_fout), .first_err_ref(n_fref));

   alsu_result_checker #(.STOP_ON_ERR(1)) u_soe (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
      .opcode(opcode), .out(out_v), .out_ref(out_ref), .leds(leds), .leds_ref(leds_ref),
      .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mis),
      .sample_cnt(s_cnt), .err_cnt(s_err), .first_err_vld(s_fvld), .first_err_idx(s_fidx),
      .first_err_op(s_fop), .first_err_out(s_fout), .first_err_ref(s_fref));

   alsu_result_checker #(.CNT_W(4)) u_c4 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
      .opcode(opcode), .out(out_v), .out_ref(out_ref), .leds(leds), .leds_ref(leds_ref),
      .busy(c_busy), .done(c_done), .pass(c_pass), .mismatch(c_mis),
      .sample_cnt(c_cnt), .err_cnt(c_err), .first_err_vld(c_fvld), .first_err_idx(c_fidx),
      .first_err_op(c_fop), .first_err_out(c_fout), .first_err_ref(c_fref));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic en;
      logic stp;
      logic [2:0] op;
      logic signed [5:0] o;
      logic signed [5:0] r;
      logic [15:0] l;
      logic [15:0] lr;
      logic exp_mis;
      int exp_cnt;
      int exp_err;
      logic exp_busy;
      logic exp_done;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_match();
      opcode = 3'b000; out_v = 6'sd5; out_ref = 6'sd5; leds = 16'hA5A5; leds_ref = 16'hA5A5;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rst = 1'b0; start = 1'b0; stop = 1'b0; sample_en = 1'b0;
      set_match();

      // vector table for the mixed pass/fail run
      for (int i = 0; i < 10; i++) begin
         vt[i].en = 1'b1; vt[i].stp = 1'b0; vt[i].op = 3'b000;
         vt[i].o = 6'sd5; vt[i].r = 6'sd5; vt[i].l = 16'hA5A5; vt[i].lr = 16'hA5A5;
         vt[i].exp_mis = 1'b0; vt[i].exp_cnt = i + 1;
         vt[i].exp_err = (i >= 9) ? 2 : ((i >= 6) ? 1 : 0);
         vt[i].exp_busy = 1'b1; vt[i].exp_done = 1'b0;
      end
      vt[6].op = 3'b010; vt[6].o = -6'sd3; vt[6].r = 6'sd2; vt[6].exp_mis = 1'b1;
      vt[9].l = 16'h0001; vt[9].lr = 16'h0000; vt[9].exp_mis = 1'b1;
      vt[10] = vt[0];
      vt[10].en = 1'b0; vt[10].stp = 1'b1; vt[10].exp_cnt = 10; vt[10].exp_err = 2;
      vt[10].exp_busy = 1'b0; vt[10].exp_done = 1'b1;

      // reset state
      do_reset();
      chk("rst_busy", d_busy, 0);
      chk("rst_done", d_done, 0);
      chk("rst_pass", d_pass, 0);
      chk("rst_cnt", d_cnt, 0);
      chk("rst_err", d_err, 0);
      chk("rst_fvld", d_fvld, 0);

      // all-matching run
      pulse_start();
      chk("t1_busy", d_busy, 1);
      sample_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t1_mis", d_mis, 0);
         chk("t1_cnt", d_cnt, i + 1);
      end
      sample_en = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_start_in_run_cnt", d_cnt, 10);
      chk("t1_start_in_run_busy", d_busy, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t1_done", d_done, 1);
      chk("t1_busy_off", d_busy, 0);
      chk("t1_pass", d_pass, 1);
      chk("t1_err", d_err, 0);
      chk("t1_fvld", d_fvld, 0);
      out_v = 6'sd1;
      sample_en = 1'b1;
      stop = 1'b1;
      tick();
      sample_en = 1'b0;
      stop = 1'b0;
      chk("t1_hold_cnt", d_cnt, 10);
      chk("t1_hold_err", d_err, 0);
      chk("t1_hold_done", d_done, 1);
      set_match();

      // mixed run from the table
      pulse_start();
      chk("t2_clr_cnt", d_cnt, 0);
      for (int i = 0; i < 11; i++) begin
         sample_en = vt[i].en; stop = vt[i].stp; opcode = vt[i].op;
         out_v = vt[i].o; out_ref = vt[i].r; leds = vt[i].l; leds_ref = vt[i].lr;
         tick();
         chk($sformatf("t2_mis[%0d]", i), d_mis, vt[i].exp_mis);
         chk($sformatf("t2_cnt[%0d]", i), d_cnt, vt[i].exp_cnt);
         chk($sformatf("t2_err[%0d]", i), d_err, vt[i].exp_err);
         chk($sformatf("t2_busy[%0d]", i), d_busy, vt[i].exp_busy);
         chk($sformatf("t2_done[%0d]", i), d_done, vt[i].exp_done);
      end
      sample_en = 1'b0; stop = 1'b0;
      set_match();
      chk("t2_fvld", d_fvld, 1);
      chk("t2_fidx", d_fidx, 6);
      chk("t2_fop", d_fop, 2);
      chk("t2_fout", d_fout, -3);
      chk("t2_fref", d_fref, 2);
      chk("t2_pass", d_pass, 0);

      // automatic DONE after NUM_SAMPLES
      do_reset();
      pulse_start();
      sample_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("t3_cnt", n_cnt, k);
         chk("t3_busy", n_busy, (k < 4) ? 1 : 0);
         chk("t3_done", n_done, (k == 4) ? 1 : 0);
      end
      out_v = 6'sd7;
      for (int k = 0; k < 3; k++) tick();
      sample_en = 1'b0;
      set_match();
      chk("t3_hold_cnt", n_cnt, 4);
      chk("t3_hold_err", n_err, 0);
      chk("t3_hold_mis", n_mis, 0);
      chk("t3_pass", n_passo, 1);

      // STOP_ON_ERR with a coincident stop
      do_reset();
      pulse_start();
      sample_en = 1'b1;
      tick();
      tick();
      out_v = 6'sd1; out_ref = 6'sd2; opcode = 3'b101;
      stop = 1'b1;
      tick();
      stop = 1'b0; sample_en = 1'b0;
      set_match();
      chk("t4_err", s_err, 1);
      chk("t4_cnt", s_cnt, 3);
      chk("t4_done", s_done, 1);
      chk("t4_mis", s_mis, 1);
      chk("t4_fidx", s_fidx, 2);
      chk("t4_fop", s_fop, 5);
      tick();
      chk("t4_mis_off", s_mis, 0);
      // STOP_ON_ERR alone ends the run
      pulse_start();
      chk("t4b_busy", s_busy, 1);
      sample_en = 1'b1; leds = 16'h0F0F;
      tick();
      sample_en = 1'b0;
      set_match();
      chk("t4b_done", s_done, 1);
      chk("t4b_cnt", s_cnt, 1);
      chk("t4b_fidx", s_fidx, 0);
      chk("t4b_pass", s_pass, 0);

      // counter saturation at CNT_W=4
      do_reset();
      pulse_start();
      sample_en = 1'b1; out_v = 6'sd1; out_ref = 6'sd0; opcode = 3'b011;
      for (int k = 0; k < 20; k++) tick();
      sample_en = 1'b0;
      chk("t5_cnt", c_cnt, 15);
      chk("t5_err", c_err, 15);
      chk("t5_fidx", c_fidx, 0);
      chk("t5_fvld", c_fvld, 1);
      chk("t5_fop", c_fop, 3);
      chk("t5_fout", c_fout, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t5_done", c_done, 1);
      chk("t5_pass", c_pass, 0);
      pulse_start();
      set_match();
      chk("t5_clr_cnt", c_cnt, 0);
      chk("t5_clr_err", c_err, 0);
      chk("t5_clr_fvld", c_fvld, 0);
      chk("t5_clr_fref", c_fref, 0);
      chk("t5_clr_mis", c_mis, 0);
      chk("t5_busy", c_busy, 1);

      // mid-run reset, then start+stop together from IDLE
      do_reset();
      pulse_start();
      sample_en = 1'b1;
      tick();
      out_v = -6'sd8; opcode = 3'b110;
      tick();
      set_match();
      tick();
      sample_en = 1'b0;
      chk("t6_err_pre", d_err, 1);
      chk("t6_cnt_pre", d_cnt, 3);
      do_reset();
      chk("t6_busy", d_busy, 0);
      chk("t6_done", d_done, 0);
      chk("t6_mis", d_mis, 0);
      chk("t6_cnt", d_cnt, 0);
      chk("t6_err", d_err, 0);
      chk("t6_fvld", d_fvld, 0);
      chk("t6_fidx", d_fidx, 0);
      chk("t6_fop", d_fop, 0);
      chk("t6_fout", d_fout, 0);
      chk("t6_fref", d_fref, 0);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("t6_ss_busy", d_busy, 1);
      chk("t6_ss_done", d_done, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
